// File: rtl/uart_rx_packet_parser.sv
// Frames UART bytes into SYNC/LEN/payload/CSUM packets and holds one validated packet for firmware.
// Optional inter-byte timeout enabled by defining UART_RX_PACKET_PARSER_TIMEOUT_EN.
module uart_rx_packet_parser #(
  parameter int unsigned MaxPayload    = 16,
  parameter logic [7:0]  SyncByte      = 8'hAA,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned AddrW = (MaxPayload > 1) ? $clog2(MaxPayload) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  input  logic             rx_error,
  input  logic [AddrW-1:0] rd_addr,
  output logic [7:0]       rd_data,
  input  logic             pkt_ack,
  output logic             pkt_ready,
  output logic [7:0]       pkt_len,
  output logic             pkt_interrupt,
  output logic             pkt_error,
  output logic             overrun
);

  if (MaxPayload < 1 || MaxPayload > 255 || TimeoutCycles < 1) begin : g_bad_params
    $error("uart_rx_packet_parser: parameter out of range");
  end

  localparam logic [8:0] MaxLen = 9'(MaxPayload);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_HOLD
  } state_t;

  state_t     state;
  logic [7:0] len_q;
  logic [7:0] acc;
  logic [7:0] count;
  logic [7:0] mem [MaxPayload];
  logic       active;
  logic       tmo_hit;
  logic       buf_we;

  assign active = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
  assign buf_we = !reset && (state == S_PAYLOAD) && rx_valid && !rx_error;

`ifdef UART_RX_PACKET_PARSER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  logic [TmoW-1:0] tmo_cnt;

  // Fires on the cycle the silent-cycle count would reach TimeoutCycles.
  assign tmo_hit = active && !rx_valid && !rx_error && (tmo_cnt == TmoLast);

  always_ff @(posedge clock) begin
    if (reset || !active || rx_valid || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      len_q         <= '0;
      acc           <= '0;
      count         <= '0;
      pkt_ready     <= 1'b0;
      pkt_len       <= '0;
      pkt_interrupt <= 1'b0;
      pkt_error     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      pkt_interrupt <= 1'b0;
      pkt_error     <= 1'b0;
      if (active && (rx_error || tmo_hit)) begin
        state     <= S_IDLE;
        pkt_error <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (rx_valid && !rx_error && (rx_byte == SyncByte)) state <= S_LEN;
          end
          S_LEN: begin
            if (rx_valid) begin
              len_q <= rx_byte;
              acc   <= rx_byte;
              count <= '0;
              if (rx_byte == 8'd0) begin
                state <= S_CSUM;
              end else if ({1'b0, rx_byte} > MaxLen) begin
                state     <= S_IDLE;
                pkt_error <= 1'b1;
              end else begin
                state <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (rx_valid) begin
              acc   <= acc ^ rx_byte;
              count <= count + 8'd1;
              if (count == len_q - 8'd1) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (rx_valid) begin
              if (rx_byte == acc) begin
                state         <= S_HOLD;
                pkt_ready     <= 1'b1;
                pkt_len       <= len_q;
                pkt_interrupt <= 1'b1;
              end else begin
                state     <= S_IDLE;
                pkt_error <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            // Release takes priority over a byte arriving in the same cycle.
            if (pkt_ack) begin
              state     <= S_IDLE;
              pkt_ready <= 1'b0;
              overrun   <= 1'b0;
            end else if (rx_valid && !rx_error) begin
              overrun <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (buf_we) mem[count[AddrW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
